lu_mem_master: RTL and testbench
================================

# lu_mem_master

Avalon-MM host engine that moves blocks of 32-bit words between streaming ports and the solver's single-port 8192×32 on-chip memory, whose read latency is fixed at one cycle with no waitrequest. The block accepts one block command at a time (read or write, base word address, length). It generates the memory's chipselect/write/address/byteenable/clken, and presents read results on a backpressured valid/ready stream. It sits between the LU datapath (matrix row fetch and writeback) and the memory's slave port.

## Interface
- ADDR_W, 13: word address width (memory depth 2^ADDR_W)
- DATA_W, 32: data width
- LEN_W, 14: command length width (max length 2^ADDR_W words)

- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_write  in  1  1 = write block, 0 = read block
- cmd_addr  in  ADDR_W  base word address
- cmd_len  in  LEN_W  word count
- wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / DATA_W  write-data stream
- rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / DATA_W  read-data stream
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at command completion
- err  out  1  one-cycle pulse on rejected command
- avm_address  out  ADDR_W  memory address
- avm_byteenable  out  4  always 4'hF while chipselect is high, else 0
- avm_chipselect / avm_write  out  1 / 1  access strobe / write qualifier
- avm_writedata  out  DATA_W  write data
- avm_clken  out  1  memory clock enable
- avm_readdata  in  DATA_W  valid the cycle after a read is issued

## Operation
- States: IDLE, READ, WRITE.
- IDLE: cmd_ready=1. On handshake:
  - If cmd_addr + cmd_len > 2^ADDR_W: err pulse next cycle, no memory access, remain IDLE.
  - Else if cmd_len = 0: done pulse next cycle, remain IDLE.
  - Else latch address and remaining count, then go to READ or WRITE.
- WRITE:
  - wr_ready=1.
  - Each wr handshake registers one beat onto the bus in the next cycle: chipselect=1, write=1, address, writedata. Address then increments.
  - After the last beat is on the bus: done pulse in the following cycle, return to IDLE.
- READ:
  - A read is issued (chipselect=1, write=0) when fifo_count + inflight − pop < 2, where pop = rd_valid & rd_ready this cycle.
  - avm_readdata is pushed into a 2-entry FIFO the cycle after issue.
  - rd_valid = FIFO not empty; rd_data = FIFO head.
  - After all words are issued and the final word is popped: done pulse next cycle, IDLE.
- Overflow of the FIFO is impossible by construction; any occurrence is a design error (assertion).
- avm_clken = 1 whenever not in reset.
- Reset mid-operation: FIFO flushed, counters cleared, state IDLE, no partial done.

## Timing
- Reset values: cmd_ready=0 during reset and 1 from the first cycle after reset release. All other outputs are 0 during reset: wr_ready, rd_valid, rd_data, busy, done, err, all avm_* signals.
- Read latency: command handshake in cycle T → first address issued in T+1 → readdata in T+2 → rd_valid in T+3.
- Throughput: 1 word/cycle sustained in both directions while the stream partner does not stall.
- Read backpressure: with rd_ready low, at most 2 words are outstanding. Issue resumes in the same cycle that a pop occurs.
- Write latency: wr handshake in cycle W → bus write in W+1. A wr_valid gap produces a bus idle cycle, with chipselect=0.
- done / err: exactly one cycle wide. busy falls in the same cycle that done rises.
- Address wraps are impossible, because out-of-range commands are rejected.

## Structure
- Package lu_mem_pkg:
  - state enum (IDLE, READ, WRITE)
  - ADDR_W / DATA_W / LEN_W defaults
  - BE_ALL = 4'hF
- Sub-module lu_skid_fifo2: 2-entry FIFO with count output, async active-low reset, and simultaneous push/pop support.

## Test plan
- Write then read back: write addr=0x100, len=4, data 0xA0..0xA3 with wr_valid constant → bus writes in 4 consecutive cycles, done 1 cycle after the last. Then read addr=0x100, len=4 with rd_ready=1 → rd_data A0,A1,A2,A3 on consecutive cycles, first at T+3.
- Read backpressure: read len=8, rd_ready toggling 1,0,0,1… → no data lost or duplicated, never more than 2 outstanding, order preserved.
- Boundary accept/reject:
  - addr=0x1FFC, len=4 → accepted, last address 0x1FFF.
  - addr=0x1FFD, len=4 → err pulse, chipselect never asserted.
- Zero length: cmd_len=0 → done pulse next cycle, no bus activity, busy stays 0.
- Reset mid-read: reset_n low after 3 of 8 words → all outputs 0 during reset. After release, cmd_ready=1, rd_valid=0, and a fresh read returns correct data.
- Write stalls: wr_valid pattern 1,0,1,1,0,1 for len=4 → chipselect follows with one-cycle delay, done after the 4th beat.

Source files
------------

// File: rtl/lu_mem_pkg.sv
// Shared types and default widths for the LU solver memory host engine.
package lu_mem_pkg;

  localparam int LU_ADDR_W = 13;
  localparam int LU_DATA_W = 32;
  localparam int LU_LEN_W  = 14;

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/lu_skid_fifo2.sv
// Two-entry FIFO holding read data returned by the memory while the stream
// consumer stalls; push and pop may occur in the same cycle.
module lu_skid_fifo2
  import lu_mem_pkg::*;
#(
  parameter int DATA_W = LU_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_pop;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    do_pop   = pop && (count_q != 2'd0);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, do_pop};
  end

  // NOTE: the two storage words are reset as well so the head reads 0 while reset is held.
  // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // The read issue throttle keeps total occupancy at two; a push into a full FIFO is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (count_q == 2'd2)));

endmodule

// File: rtl/lu_mem_master.sv
// Avalon-MM host moving blocks of words between the write/read streams and the
// solver's single-port on-chip memory (one-cycle read latency, no waitrequest).
module lu_mem_master
  import lu_mem_pkg::*;
#(
  parameter int ADDR_W = LU_ADDR_W,
  parameter int DATA_W = LU_DATA_W,
  parameter int LEN_W  = LU_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,

  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,

  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,

  output logic              busy,
  output logic              done,
  output logic              err,

  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_clken,
  input  logic [DATA_W-1:0] avm_readdata
);

  localparam logic [LEN_W:0] DEPTH = (LEN_W + 1)'(2 ** ADDR_W);

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_cs_q, wr_cs_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_pend_q, rd_pend_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              cmd_hs;
  logic              wr_hs;
  logic              rd_pop;
  logic              rd_issue;
  logic [1:0]        fifo_count;
  logic [2:0]        rd_occ;
  logic [LEN_W:0]    end_sum;
  logic              range_bad;

  lu_skid_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rd_pend_q),
    .push_data (avm_readdata),
    .pop       (rd_pop),
    .head_data (rd_data),
    .count     (fifo_count)
  );

  assign cmd_hs   = cmd_valid && cmd_ready_q;
  assign wr_ready = (state_q == ST_WRITE) && (rem_q != '0);
  assign wr_hs    = wr_valid && wr_ready;
  assign rd_valid = (fifo_count != 2'd0);
  assign rd_pop   = rd_valid && rd_ready;

  // Reads are issued combinationally so a pop frees a slot in the same cycle;
  // FIFO words plus the word returning this cycle may never exceed two.
  assign rd_occ   = {1'b0, fifo_count} + {2'b00, rd_pend_q} - {2'b00, rd_pop};
  assign rd_issue = (state_q == ST_READ) && (rem_q != '0) && (rd_occ < 3'd2);

  assign end_sum   = {{(LEN_W + 1 - ADDR_W){1'b0}}, cmd_addr} + {1'b0, cmd_len};
  assign range_bad = (end_sum > DEPTH);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    wr_cs_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_pend_d = rd_issue;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
            state_d = cmd_write ? ST_WRITE : ST_READ;
          end
        end
      end

      ST_READ: begin
        if (rd_issue) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
        end
        // Last word leaves the FIFO with nothing issued or returning behind it.
        if ((rem_q == '0) && !rd_pend_q && (fifo_count == 2'd1) && rd_pop) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (wr_hs) begin
          wr_cs_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = wr_data;
          addr_d    = addr_q + ADDR_W'(1);
          rem_d     = rem_q - LEN_W'(1);
        end
        if (wr_cs_q && (rem_q == '0)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rem_q       <= '0;
      addr_q      <= '0;
      wr_cs_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_pend_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      wr_cs_q     <= wr_cs_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_pend_q   <= rd_pend_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign err            = err_q;
  assign avm_chipselect = wr_cs_q || rd_issue;
  assign avm_write      = wr_cs_q;
  assign avm_address    = wr_cs_q ? wr_addr_q : (rd_issue ? addr_q : '0);
  assign avm_writedata  = wr_data_q;
  assign avm_byteenable = avm_chipselect ? BE_ALL : 4'h0;
  assign avm_clken      = reset_n;

endmodule

// File: tb/tb_lu_mem_master.sv
// Directed bench for lu_mem_master: a table of block commands plus hand-written
// sequences for write stalls, read backpressure and reset in mid-read.
module tb_lu_mem_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [12:0] cmd_addr;
  logic [13:0] cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic [12:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect, avm_write, avm_clken;
  logic [31:0] avm_writedata, avm_readdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_mem [8192];
  logic [31:0] mem     [8192];
  bit          written [8192];

  lu_mem_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_clken      (avm_clken),
    .avm_readdata   (avm_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_pat(input logic [12:0] a);
    return 32'hC000_0000 | {19'd0, a};
  endfunction

  // Slave model: one-cycle read latency, unwritten words return init_pat.
  always @(posedge clk) begin
    if (!reset_n) begin
      avm_readdata <= '0;
    end else if (avm_clken && avm_chipselect) begin
      if (avm_write) begin
        if (avm_byteenable == 4'hF) begin
          mem[avm_address]     <= avm_writedata;
          written[avm_address] <= 1'b1;
        end
      end else begin
        avm_readdata <= written[avm_address] ? mem[avm_address] : init_pat(avm_address);
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts and ends half a step after a rising edge; handshake on the next edge.
  task automatic send_cmd(input bit w, input logic [12:0] a, input logic [13:0] l);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
    check("cmd_ready idle", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
  endtask

  task automatic run_quick(input bit w, input logic [12:0] addr, input int len,
                           input bit exp_err, input string tag);
    send_cmd(w, addr, 14'(len));
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      check({tag, " err"}, err, exp_err && (cyc == 0));
      check({tag, " done"}, done, !exp_err && (cyc == 0));
      check({tag, " quiet"}, {busy, avm_chipselect, wr_ready, rd_valid}, 4'b0000);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_write(input logic [12:0] addr, input int len, input logic [31:0] base,
                           input logic [7:0] vpat, input int plen, input string tag);
    int sent = 0;
    int bus  = 0;
    bit hs_prev = 1'b0;
    bit last_prev = 1'b0;
    bit finished = 1'b0;
    send_cmd(1'b1, addr, 14'(len));
    for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
      wr_valid = (sent < len) && ((cyc >= plen) || vpat[cyc]);
      wr_data  = base + sent;
      @(negedge clk);
      check({tag, " wr_ready"}, wr_ready, sent < len);
      check({tag, " done"}, done, last_prev);
      check({tag, " busy"}, busy, !last_prev);
      if (last_prev) finished = 1'b1;
      check({tag, " cs"}, avm_chipselect, hs_prev);
      if (hs_prev) begin
        check({tag, " wr addr"}, {avm_write, avm_byteenable, avm_address},
              {1'b1, 4'hF, addr + 13'(bus)});
        check({tag, " wr data"}, avm_writedata, base + bus);
        bus++;
      end
      last_prev = hs_prev && (bus == len);
      hs_prev   = wr_valid && (sent < len);
      if (hs_prev) begin
        exp_mem[addr + 13'(sent)] = base + sent;
        sent++;
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    check({tag, " completed"}, finished, 1'b1);
    @(negedge clk);
    check({tag, " done width"}, done, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic run_read(input logic [12:0] addr, input int len, input logic [3:0] rpat,
                          input int abort_after, input string tag);
    int issued = 0;
    int popped = 0;
    int max_out = 0;
    bit last_prev = 1'b0;
    bit finished = 1'b0;
    bit aborted = 1'b0;
    send_cmd(1'b0, addr, 14'(len));
    for (int cyc = 0; cyc < 200 && !finished && !aborted; cyc++) begin
      rd_ready = rpat[cyc % 4];
      @(negedge clk);
      if (cyc == 0)
        check({tag, " first issue"}, {avm_chipselect, avm_write, avm_address}, {2'b10, addr});
      if (cyc == 1) check({tag, " rd_valid T+2"}, rd_valid, 1'b0);
      if (cyc == 2) check({tag, " rd_valid T+3"}, rd_valid, 1'b1);
      check({tag, " done"}, done, last_prev);
      check({tag, " busy"}, busy, !last_prev);
      if (last_prev) begin
        finished = 1'b1;
        if (rpat == 4'hF) check({tag, " done cycle"}, cyc, len + 2);
      end
      if (avm_chipselect) begin
        check({tag, " rd addr"}, {avm_write, avm_byteenable, avm_address},
              {1'b0, 4'hF, addr + 13'(issued)});
        issued++;
      end
      last_prev = 1'b0;
      if (rd_valid && rd_ready) begin
        check({tag, " rd data"}, rd_data, exp_mem[addr + 13'(popped)]);
        popped++;
        last_prev = (popped == len);
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (abort_after != 0 && popped == abort_after) aborted = 1'b1;
      @(posedge clk); #1;
    end
    if (!aborted) begin
      check({tag, " completed"}, finished, 1'b1);
      check({tag, " issued"}, issued, len);
      check({tag, " popped"}, popped, len);
      check({tag, " max outstanding"}, max_out <= 2, 1'b1);
      @(negedge clk);
      check({tag, " done width"}, done, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [12:0] addr;
    int          len;
    logic [31:0] base;
    bit          exp_err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    for (int i = 0; i < 8192; i++) exp_mem[i] = init_pat(13'(i));

    vecs[0]  = '{1'b1, 13'h0100, 4, 32'h0000_00A0, 1'b0};
    vecs[1]  = '{1'b0, 13'h0100, 4, 32'h0,         1'b0};
    vecs[2]  = '{1'b1, 13'h1FFC, 4, 32'h0000_5000, 1'b0};
    vecs[3]  = '{1'b0, 13'h1FFC, 4, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 13'h1FFD, 4, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 13'h1FFD, 4, 32'h0,         1'b1};
    vecs[6]  = '{1'b0, 13'h0010, 0, 32'h0,         1'b0};
    vecs[7]  = '{1'b1, 13'h0020, 0, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 13'h1FFF, 2, 32'h0,         1'b1};
    vecs[9]  = '{1'b0, 13'h0000, 1, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 13'h1FFF, 1, 32'h0,         1'b0};

    @(negedge clk);
    check("reset outputs",
          {cmd_ready, wr_ready, rd_valid, busy, done, err, avm_chipselect, avm_write,
           avm_clken, avm_byteenable, avm_address, avm_writedata, rd_data}, '0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("after reset", {cmd_ready, avm_clken, busy, rd_valid}, 4'b1100);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].exp_err || vecs[i].len == 0)
        run_quick(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].exp_err, $sformatf("v%0d", i));
      else if (vecs[i].wr)
        run_write(vecs[i].addr, vecs[i].len, vecs[i].base, 8'h00, 0, $sformatf("v%0d", i));
      else
        run_read(vecs[i].addr, vecs[i].len, 4'hF, 0, $sformatf("v%0d", i));
    end

    // wr_valid pattern 1,0,1,1,0,1 then read back
    run_write(13'h0200, 4, 32'h0000_00B0, 8'b0010_1101, 6, "stall wr");
    run_read(13'h0200, 4, 4'hF, 0, "stall rb");

    // rd_ready pattern 1,0,0,1 repeating
    run_read(13'h0300, 8, 4'b1001, 0, "backpressure");

    // Reset after three of eight words have been delivered
    run_read(13'h0400, 8, 4'hF, 3, "rst pre");
    reset_n = 1'b0;
    @(negedge clk);
    check("mid reset outputs",
          {cmd_ready, wr_ready, rd_valid, busy, done, err, avm_chipselect, avm_write,
           avm_clken, avm_byteenable, avm_address, avm_writedata, rd_data}, '0);
    #2 reset_n = 1'b1;
    rd_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post reset", {cmd_ready, rd_valid, busy, done}, 4'b1000);
    @(posedge clk); #1;
    run_read(13'h0400, 4, 4'hF, 0, "rst fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
